led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern engine for the board top level. It replaces the bare free-running counter that drives the user LEDs. It drives NUM_LEDS outputs in one of four selectable modes (binary count, blink, bounce, PWM breathe). A debounced push-button steps through the modes, a second button restarts the pattern, and the slide switches set the speed. It sits beside the soc instance, clocked from the 50 MHz fabric clock, with KEY, SW and LED wired directly to it.

## Interface
- NUM_LEDS, 8, number of LED outputs (≥2)
- BASE_DIV, 65536, tick divisor at speed 0 (≥1); BASE_DIV<<15 must fit in PRESCALE_W bits
- PRESCALE_W, 32, tick prescaler width
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level (≥1)
- PWM_W, 8, breathe-mode PWM resolution in bits
- clk  in  1  fabric clock; single clock domain
- reset  in  1  synchronous, active-high reset
- key_n  in  2  raw push-buttons, active-low, asynchronous; [0] = next mode, [1] = restart pattern
- sw  in  4  raw slide switches, asynchronous; speed exponent
- led  out  NUM_LEDS  registered LED drive, 1 = lit
- mode  out  2  current mode: 0 COUNT, 1 BLINK, 2 BOUNCE, 3 BREATHE
- tick  out  1  one-cycle pattern-step strobe (debug)

## Operation
- Synchronisers: key_n and sw each pass through a 2-flop synchroniser. All logic below uses the synchronised values.
- Debounce (per key):
  - A stable level register resets to 1.
  - A counter runs while the synced level differs from the stable level, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synced value.
  - A stable 1→0 transition produces a one-cycle press event. Release produces no event.
- Tick generator:
  - term = (BASE_DIV << sw_sync) − 1.
  - The prescaler p increments every cycle.
  - When p ≥ term: tick=1 and p←0. Otherwise tick=0.
  - A speed change therefore takes effect without waiting for the old period to expire.
- Mode register:
  - Resets to 0.
  - press[0] sets mode ← mode+1 mod 4 and clears the pattern state.
  - press[1] clears the pattern state and leaves mode unchanged.
  - Both presses in the same cycle: mode advances and the state is cleared once.
  - A clear takes priority over a tick in the same cycle.
- Pattern state clear values: cnt=0, blink=0, pos=0, dir=up, duty=0, duty_dir=up. The prescaler is not cleared.
- State advances only on tick, and only for the active mode:
  - COUNT: cnt (NUM_LEDS bits) increments, wrapping 2^NUM_LEDS−1 → 0. led = cnt.
  - BLINK: blink toggles. led = all ones if blink, else all zeros.
  - BOUNCE: led = 1<<pos. pos steps by ±1.
    - At pos=NUM_LEDS−1 going up: dir←down, pos←NUM_LEDS−2.
    - At pos=0 going down: dir←up, pos←1.
    - Period is 2·NUM_LEDS−2 ticks.
  - BREATHE: duty steps through a triangle 0 → 2^PWM_W−1 → 0 (endpoints not repeated).
    - The PWM counter (PWM_W bits) runs every cycle, independent of tick and clear.
    - Every led bit = (pwm_cnt < duty).
    - duty=0 keeps LEDs fully off. The maximum duty gives 2^PWM_W−1 on-cycles out of 2^PWM_W.

## Timing
- Reset values: led=0, mode=0, tick=0, p=0, pwm_cnt=0, debounce stable levels=1, all pattern state at its clear value.
- led is registered from the current state: a state change appears on led one cycle later.
- mode is the register output itself.
- Key latency:
  - A raw key_n edge held stable is synchronised in 2 cycles and accepted after DEBOUNCE_CYCLES more cycles.
  - The press event, the mode change and the clear are applied on the next edge.
  - led reflects the new mode one cycle after that.
- A bounce shorter than DEBOUNCE_CYCLES produces no event.
- sw latency: 2 cycles to term. Tick spacing is exactly term+1 cycles while sw is stable.
- Reset asserted mid-pattern returns every register to its reset value on the next edge.

## Test plan
Bench parameters: NUM_LEDS=8, BASE_DIV=4, DEBOUNCE_CYCLES=8, PWM_W=4.
- Reset then release, sw=0 -> tick every 4 cycles; led=0x00,0x01,0x02…; after 256 ticks led wraps 0xFF→0x00; mode=0.
- COUNT running, set sw=2 -> after the sync delay, tick every 16 cycles; sw back to 0 mid-period -> tick within 2+1 cycles, then every 4 cycles.
- key_n[0] low for 5 cycles, then high -> mode stays 0; key_n[0] low for 20 cycles -> exactly one mode change 0→1 at cycle 2+8+1 after the edge; BLINK alternates 0x00/0xFF per tick; release with a 3-cycle chatter -> no further change.
- Advance to BOUNCE -> led sequence 0x01,0x02,…,0x80,0x40,…,0x01,0x02 (period 14 ticks); key_n[1] press mid-sweep -> led returns to 0x01 with dir up; mode stays 2.
- BREATHE -> with duty=8, each led bit high for 8 of every 16 cycles; duty climbs to 15, then steps to 14, and returns to 0 at tick 30; a full mode cycle from 3 wraps to 0.
- Both keys pressed in the same cycle in mode 1 -> mode=2, pos=0, single event; assert reset mid-BOUNCE -> next edge: led=0, mode=0, tick=0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: user-LED pattern engine with four modes (count, blink,
// bounce, PWM breathe), debounced next-mode / restart keys and a
// switch-selected pattern speed.
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS        = 8,
    parameter int unsigned BASE_DIV        = 65536,
    parameter int unsigned PRESCALE_W      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PWM_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          key_n,
    input  logic [3:0]          sw,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                tick
);

    localparam int unsigned POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [1:0]          key_meta;
    logic [1:0]          key_sync;
    logic [3:0]          sw_meta;
    logic [3:0]          sw_sync;
    logic [1:0]          key_stable;
    logic [1:0]          key_stable_d;
    logic [DB_W-1:0]     db_cnt [2];
    logic [1:0]          press_c;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] term_c;
    mode_e               mode_q;
    mode_e               mode_d;
    logic                clear_c;
    logic [NUM_LEDS-1:0] cnt;
    logic                blink;
    logic [POS_W-1:0]    pos;
    logic                pos_up;
    logic [PWM_W-1:0]    duty;
    logic                duty_up;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [NUM_LEDS-1:0] led_c;

    // Two-flop synchronisers for the asynchronous keys and switches
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            key_stable   <= 2'b11;
            key_stable_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_stable_d <= key_stable;
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == key_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]     <= '0;
                    key_stable[i] <= key_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the one-cycle stable 1->0 transition; release is ignored
    assign press_c = key_stable_d & ~key_stable;

    // Terminal count follows the synchronised switches immediately
    assign term_c = (PRESCALE_W'(BASE_DIV) << sw_sync) - PRESCALE_W'(1);

    // Free-running prescaler producing the pattern-step strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            tick     <= 1'b0;
        end else if (prescale >= term_c) begin
            prescale <= '0;
            tick     <= 1'b1;
        end else begin
            prescale <= prescale + PRESCALE_W'(1);
            tick     <= 1'b0;
        end
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_COUNT;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next-state: key 0 advances, either key clears the pattern state
    always_comb begin
        mode_d  = mode_q;
        clear_c = |press_c;
        if (press_c[0]) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
    end

    assign mode = mode_q;

    // Pattern state: clear wins over tick; only the active mode advances
    always_ff @(posedge clk) begin
        if (reset || clear_c) begin
            cnt     <= '0;
            blink   <= 1'b0;
            pos     <= '0;
            pos_up  <= 1'b1;
            duty    <= '0;
            duty_up <= 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: begin
                    cnt <= cnt + NUM_LEDS'(1);
                end
                MODE_BLINK: begin
                    blink <= ~blink;
                end
                MODE_BOUNCE: begin
                    if (pos_up) begin
                        if (pos == POS_MAX) begin
                            pos_up <= 1'b0;
                            pos    <= POS_MAX - POS_W'(1);
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_up <= 1'b1;
                            pos    <= POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (duty_up) begin
                        if (duty == DUTY_MAX) begin
                            duty_up <= 1'b0;
                            duty    <= DUTY_MAX - PWM_W'(1);
                        end else begin
                            duty <= duty + PWM_W'(1);
                        end
                    end else begin
                        if (duty == '0) begin
                            duty_up <= 1'b1;
                            duty    <= PWM_W'(1);
                        end else begin
                            duty <= duty - PWM_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // LED image for the current mode and state
    always_comb begin
        led_c = '0;
        case (mode_q)
            MODE_COUNT:   led_c = cnt;
            MODE_BLINK:   led_c = {NUM_LEDS{blink}};
            MODE_BOUNCE:  led_c = NUM_LEDS'(1) << pos;
            MODE_BREATHE: led_c = {NUM_LEDS{pwm_cnt < duty}};
            default:      led_c = '0;
        endcase
    end

    // PWM counter runs every cycle; LED drive is registered
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            led     <= led_c;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed plus randomized stimulus against a behavioural
// model that derives LED images from the number of ticks since the last clear.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_n;
    logic [3:0] sw;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [1:0] key_d1, key_d2;
    logic [3:0] sw_d1, sw_d2;
    logic [1:0] sync_hist[$];
    logic [1:0] stable_m;
    logic [1:0] pend_m;
    int         since_m;
    logic       tick_m;
    logic [1:0] mode_m;
    int         k_m;
    int         pwm_m;
    logic [7:0] led_m;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LEDS(8),
        .BASE_DIV(4),
        .PRESCALE_W(32),
        .DEBOUNCE_CYCLES(8),
        .PWM_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .sw(sw),
        .led(led),
        .mode(mode),
        .tick(tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // LED image after kk ticks since the last clear
    function automatic logic [7:0] pattern(input int md, input int kk, input int pw);
        int m;
        int p;
        case (md)
            0: return 8'(kk % 256);
            1: return (kk % 2 == 1) ? 8'hFF : 8'h00;
            2: begin
                m = kk % 14;
                p = (m < 8) ? m : 14 - m;
                return 8'(1 << p);
            end
            default: begin
                m = kk % 30;
                p = (m <= 15) ? m : 30 - m;
                return (pw < p) ? 8'hFF : 8'h00;
            end
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        logic [1:0] syn_k;
        logic [3:0] syn_sw;
        int         term;
        logic       fire;
        logic       all_flip;
        if (reset) begin
            key_d1 = 2'b11; key_d2 = 2'b11;
            sw_d1 = 4'd0;   sw_d2 = 4'd0;
            sync_hist.delete();
            stable_m = 2'b11; pend_m = 2'b00;
            since_m = 0; tick_m = 1'b0; mode_m = 2'd0;
            k_m = 0; pwm_m = 0; led_m = 8'h00;
            return;
        end
        led_m = pattern(int'(mode_m), k_m, pwm_m);
        if (pend_m != 2'b00) begin
            if (pend_m[0]) mode_m = mode_m + 2'd1;
            k_m = 0;
        end else if (tick_m) begin
            k_m++;
        end
        pwm_m = (pwm_m + 1) % 16;
        syn_k  = key_d2;
        syn_sw = sw_d2;
        key_d2 = key_d1; key_d1 = key_n;
        sw_d2  = sw_d1;  sw_d1  = sw;
        term = (4 << syn_sw) - 1;
        fire = (since_m >= term);
        since_m = fire ? 0 : since_m + 1;
        tick_m = fire;
        sync_hist.push_back(syn_k);
        if (sync_hist.size() > 8) void'(sync_hist.pop_front());
        pend_m = 2'b00;
        for (int i = 0; i < 2; i++) begin
            all_flip = (sync_hist.size() == 8);
            foreach (sync_hist[j]) begin
                if (sync_hist[j][i] == stable_m[i]) all_flip = 1'b0;
            end
            if (all_flip) begin
                if (stable_m[i]) pend_m[i] = 1'b1;
                stable_m[i] = ~stable_m[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("led", 32'(led), 32'(led_m));
        check("mode", 32'(mode), 32'(mode_m));
        check("tick", 32'(tick), 32'(tick_m));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [1:0] low_mask, input int hold);
        key_n = ~low_mask;
        run(hold);
        key_n = 2'b11;
        run(hold);
    endtask

    initial begin
        int len;
        int r;
        reset = 1'b1;
        key_n = 2'b11;
        sw    = 4'd0;
        run(3);
        check("rst_led", 32'(led), 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        reset = 1'b0;

        // COUNT through a full wrap
        run(1100);

        // Speed change and quick return
        sw = 4'd2;
        run(100);
        sw = 4'd0;
        run(40);

        // Short glitch gives no event
        key_n = 2'b10;
        run(5);
        key_n = 2'b11;
        run(30);
        check("glitch_mode", 32'(mode), 32'h0);

        // Real press: mode changes exactly 2+8+1 edges after the key edge
        key_n = 2'b10;
        run(10);
        check("press_early", 32'(mode), 32'h0);
        run(1);
        check("press_edge", 32'(mode), 32'h1);
        run(9);
        key_n = 2'b11; run(1);
        key_n = 2'b10; run(3);
        key_n = 2'b11; run(40);
        check("chatter_mode", 32'(mode), 32'h1);
        run(40);

        // BOUNCE sweep, then restart mid-sweep
        press(2'b01, 15);
        check("bounce_mode", 32'(mode), 32'h2);
        run(80);
        press(2'b10, 15);
        check("restart_mode", 32'(mode), 32'h2);
        run(40);

        // BREATHE triangle and mode wrap
        press(2'b01, 15);
        check("breathe_mode", 32'(mode), 32'h3);
        run(200);
        press(2'b01, 15);
        check("wrap_mode", 32'(mode), 32'h0);

        // Both keys together in BLINK
        press(2'b01, 15);
        press(2'b11, 15);
        check("both_mode", 32'(mode), 32'h2);
        run(30);

        // Reset mid-BOUNCE
        reset = 1'b1;
        run(1);
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_mode", 32'(mode), 32'h0);
        check("midrst_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        run(20);

        // Randomized key bursts, speed changes and occasional resets
        for (int s = 0; s < 200; s++) begin
            len = $urandom_range(1, 24);
            r   = $urandom_range(0, 9);
            if (r < 6) key_n = 2'b11;
            else       key_n = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 2));
            reset = ($urandom_range(0, 60) == 0);
            run(len);
            reset = 1'b0;
        end
        key_n = 2'b11;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
